mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  RV32I writeback stage between the MEM pipeline register and the register file.
//  Accepts one instruction per cycle from MEM and waits for load data from the data-memory response port.
//  Aligns and extends load data, then selects the ALU, load or PC+4 result.
//  Drives the single register-file write port (rd_wb, rd_wb_data, RegWrite) and stalls MEM while a load is outstanding.
// PARAMETERS
//  XLEN      32  datapath width
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk             in   1     rising-edge clock
//  rst_n           in   1     reset, asynchronous assert, active-low
//  ex_valid        in   1     MEM presents an instruction
//  ex_ready        out  1     stage can accept; high only in IDLE
//  flush           in   1     kill the instruction presented this cycle
//  ex_rd           in   5     destination register
//  ex_reg_write    in   1     instruction writes rd
//  ex_mem_read     in   1     instruction is a load
//  ex_funct3       in   3     load size/sign (LB 000 LH 001 LW 010 LBU 100 LHU 101)
//  ex_addr_lo      in   2     byte offset of load address
//  ex_wb_sel       in   2     00 ALU, 01 MEM, 10 PC+4, 11 ALU
//  ex_alu_result   in   XLEN  ALU result
//  ex_pc_plus4     in   XLEN  link value
//  dmem_rsp_valid  in   1     load data valid this cycle
//  dmem_rdata      in   XLEN  raw aligned word from data memory
//  rd_wb           out  5     register-file write address
//  rd_wb_data      out  XLEN  register-file write data
//  RegWrite        out  1     register-file write enable, one-cycle pulse per commit
//  retire_cnt      out  CNT_W committed-instruction count
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; rd_wb=0, rd_wb_data=0, RegWrite=0, retire_cnt=0.
//    ex_ready reads 1 because state is IDLE. A pending load is dropped with no commit.
//  - Accept = ex_valid & ex_ready & ~flush. flush with ex_valid: no accept, no commit, no state change.
//  - States: IDLE, WAIT_MEM.
//    IDLE, accept, ex_mem_read=0: compute the result and register it; commit visible cycle N+1; stay in IDLE.
//    IDLE, accept, ex_mem_read=1: latch rd, funct3, addr_lo and reg_write; go to WAIT_MEM; no commit.
//    WAIT_MEM: ex_ready=0. On dmem_rsp_valid at cycle M, extract the data, commit at M+1, return to IDLE.
//    WAIT_MEM ignores flush, because the load is older than any redirect.
//    dmem_rsp_valid in IDLE is ignored.
//  - Throughput: back-to-back non-loads commit once per cycle. A load costs response latency + 1.
//  - Load extract uses dmem_rdata shifted right by 8*addr_lo.
//    LB/LH sign-extend; LBU/LHU zero-extend; LW and reserved funct3 take the full word.
//    LH/LHU with addr_lo=3 use bits [31:24] and zero-fill the upper byte.
//  - Commit cycle:
//    RegWrite = reg_write & (rd != 0); rd_wb = rd; rd_wb_data = selected result.
//    In non-commit cycles RegWrite=0; rd_wb and rd_wb_data hold their last values.
//  - retire_cnt increments on every commit, including rd=0 and reg_write=0; it wraps modulo 2^CNT_W.
//  - Reset asserted in WAIT_MEM: returns to IDLE immediately; a late dmem_rsp_valid is ignored.
// STRUCTURE
//  - Shared package rv32i_pkg:
//    WB_SEL_ALU/MEM/PC4 constants; F3_LB/LH/LW/LBU/LHU constants; wb_state_t enum {IDLE, WAIT_MEM}.
//  - Sub-module load_extend: combinational (funct3, addr_lo, rdata) -> XLEN result; reused by the LSU.
//  - Top holds the FSM, the latched load context, the output registers and the counter.
// TESTING
//  1. ADD: ex_rd=5, wb_sel=ALU, alu=0x1234 at N -> RegWrite=1, rd_wb=5, data=0x1234 at N+1; retire_cnt=1.
//  2. LB: addr_lo=2, rdata=0x0080_0000, rsp 3 cycles after accept.
//     -> ex_ready=0 for 3 cycles; data=0xFFFF_FF80 one cycle after the rsp.
//     LBU with the same stimulus -> 0x0000_0080.
//  3. JAL: rd=1, wb_sel=PC4, pc_plus4=0x100 -> data=0x100. Same with rd=0 -> RegWrite=0, retire_cnt still +1.
//  4. flush=1 with ex_valid -> no commit, counter unchanged.
//     flush during WAIT_MEM -> load still commits.
//  5. rst_n low in WAIT_MEM, then rsp pulse after release -> no RegWrite; ex_ready=1; all outputs 0.
//  6. Four back-to-back ALU ops -> four consecutive RegWrite pulses; retire_cnt=4.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types used by the writeback stage and the LSU.
package rv32i_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Writeback result select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension for RV32I LB/LH/LW/LBU/LHU.
module load_extend
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Zeros shift in from the top, so a halfword at offset 3 gets a zero upper byte.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{(XLEN - 8){shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{(XLEN - 16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  result = {{(XLEN - 8){1'b0}}, shifted[7:0]};
            F3_LHU:  result = {{(XLEN - 16){1'b0}}, shifted[15:0]};
            F3_LW:   result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I writeback stage: waits for load data, extends it, selects the result and
// drives the single register-file write port plus a retired-instruction counter.
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             flush,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [2:0]       ex_funct3,
    input  logic [1:0]       ex_addr_lo,
    input  logic [1:0]       ex_wb_sel,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_pc_plus4,
    input  logic             dmem_rsp_valid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [4:0]       rd_wb,
    output logic [XLEN-1:0]  rd_wb_data,
    output logic             RegWrite,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_state_t state_q, state_d;

    logic [4:0] ld_rd_q;
    logic [2:0] ld_funct3_q;
    logic [1:0] ld_addr_lo_q;
    logic       ld_reg_write_q;

    logic            accept;
    logic            commit;
    logic [4:0]      commit_rd;
    logic            commit_we;
    logic [XLEN-1:0] commit_data;
    logic [XLEN-1:0] nonload_data;
    logic [XLEN-1:0] load_data;

    logic [4:0]       rd_wb_q;
    logic [XLEN-1:0]  rd_wb_data_q;
    logic             reg_write_q;
    logic [CNT_W-1:0] retire_cnt_q;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .funct3 (ld_funct3_q),
        .addr_lo(ld_addr_lo_q),
        .rdata  (dmem_rdata),
        .result (load_data)
    );

    // A non-load selecting MEM has no memory data, so it falls back to the ALU result.
    always_comb begin
        nonload_data = ex_alu_result;
        case (ex_wb_sel)
            WB_SEL_ALU: nonload_data = ex_alu_result;
            WB_SEL_MEM: nonload_data = ex_alu_result;
            WB_SEL_PC4: nonload_data = ex_pc_plus4;
            default:    nonload_data = ex_alu_result;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        commit_rd   = ex_rd;
        commit_we   = ex_reg_write;
        commit_data = nonload_data;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_mem_read) begin
                        state_d = WAIT_MEM;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Flush is ignored here: the outstanding load is older than any redirect.
                commit_rd   = ld_rd_q;
                commit_we   = ld_reg_write_q;
                commit_data = load_data;
                if (dmem_rsp_valid) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd_q        <= '0;
            ld_funct3_q    <= '0;
            ld_addr_lo_q   <= '0;
            ld_reg_write_q <= 1'b0;
        end else if (accept && ex_mem_read) begin
            ld_rd_q        <= ex_rd;
            ld_funct3_q    <= ex_funct3;
            ld_addr_lo_q   <= ex_addr_lo;
            ld_reg_write_q <= ex_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wb_q      <= '0;
            rd_wb_data_q <= '0;
            reg_write_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            reg_write_q <= commit & commit_we & (commit_rd != 5'd0);
            if (commit) begin
                rd_wb_q      <= commit_rd;
                rd_wb_data_q <= commit_data;
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rd_wb      = rd_wb_q;
    assign rd_wb_data = rd_wb_data_q;
    assign RegWrite   = reg_write_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected commits are queued at issue and
// popped whenever the retire counter advances.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        flush = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [1:0]  ex_addr_lo = '0;
    logic [1:0]  ex_wb_sel = '0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_pc_plus4 = '0;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [4:0]  rd_wb;
    logic [31:0] rd_wb_data;
    logic        RegWrite;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] prev_cnt = '0;

    mem_wb_stage #(
        .XLEN (32),
        .CNT_W(32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_funct3     (ex_funct3),
        .ex_addr_lo    (ex_addr_lo),
        .ex_wb_sel     (ex_wb_sel),
        .ex_alu_result (ex_alu_result),
        .ex_pc_plus4   (ex_pc_plus4),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata    (dmem_rdata),
        .rd_wb         (rd_wb),
        .rd_wb_data    (rd_wb_data),
        .RegWrite      (RegWrite),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] alo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (alo)
            2'd0: begin b = w[7:0];   h = w[15:0];          end
            2'd1: begin b = w[15:8];  h = w[23:8];          end
            2'd2: begin b = w[23:16]; h = w[31:16];         end
            default: begin b = w[31:24]; h = {8'h00, w[31:24]}; end
        endcase
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Monitor: a retire-counter step is a commit; RegWrite must never pulse without one.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cnt = '0;
        end else begin
            if (retire_cnt != prev_cnt) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_commit", 64'(retire_cnt), 64'(prev_cnt));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("commit_rd", 64'(rd_wb), 64'(e.rd));
                    check_eq("commit_data", 64'(rd_wb_data), 64'(e.data));
                    check_eq("commit_we", 64'(RegWrite), 64'(e.we));
                    check_eq("cnt_step", 64'(retire_cnt), 64'(prev_cnt + 32'd1));
                end
            end else begin
                check_eq("we_without_commit", 64'(RegWrite), 64'd0);
            end
            prev_cnt = retire_cnt;
        end
    end

    task automatic set_op(input logic [4:0] rd, input logic we, input logic mr,
                          input logic [2:0] f3, input logic [1:0] alo, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_reg_write  = we;
        ex_mem_read   = mr;
        ex_funct3     = f3;
        ex_addr_lo    = alo;
        ex_wb_sel     = sel;
        ex_alu_result = alu;
        ex_pc_plus4   = pc4;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic we);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.we   = we & (rd != 5'd0);
        sb.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] pc4);
        push_exp(rd, (sel == 2'b10) ? pc4 : alu, we);
        set_op(rd, we, 1'b0, 3'b000, 2'b00, sel, alu, pc4);
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    // Load with response 'lat' cycles after the accept edge; ex_ready must stay low meanwhile.
    task automatic issue_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                              input logic [1:0] alo, input logic [31:0] w, input int lat);
        push_exp(rd, model_load(f3, alo, w), 1'b1);
        set_op(rd, 1'b1, 1'b1, f3, alo, 2'b01, 32'hDEAD_0000, 32'h0);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check_eq({tag, "_ready_low"}, 64'(ex_ready), 64'd0);
            if (i == lat - 1) begin
                dmem_rsp_valid = 1'b1;
                dmem_rdata     = w;
            end
        end
        @(posedge clk);
        #1 dmem_rsp_valid = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        check_eq({tag, "_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
        check_eq({tag, "_ready"}, 64'(ex_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(ex_ready), 64'd1);
        check_eq({tag, "_we"}, 64'(RegWrite), 64'd0);
        check_eq({tag, "_rd"}, 64'(rd_wb), 64'd0);
        check_eq({tag, "_data"}, 64'(rd_wb_data), 64'd0);
        check_eq({tag, "_cnt"}, 64'(retire_cnt), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD x5
        issue_alu(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0);
        drain("add");
        check_eq("add_cnt_is_1", 64'(retire_cnt), 64'd1);

        // LB / LBU at offset 2, response 3 cycles after accept
        issue_load("lb", 5'd7, 3'b000, 2'd2, 32'h0080_0000, 3);
        drain("lb");
        issue_load("lbu", 5'd8, 3'b100, 2'd2, 32'h0080_0000, 3);
        drain("lbu");
        // LH at offset 3 zero-fills; LH sign-extends; LW ignores offset; reserved funct3 full word
        issue_load("lh3", 5'd9, 3'b001, 2'd3, 32'h8000_0000, 1);
        issue_load("lh0", 5'd10, 3'b001, 2'd0, 32'h1234_8001, 2);
        issue_load("lhu2", 5'd11, 3'b101, 2'd2, 32'hF00D_0000, 1);
        issue_load("lw", 5'd12, 3'b010, 2'd1, 32'hCAFE_BABE, 2);
        issue_load("rsv", 5'd13, 3'b111, 2'd3, 32'h0BAD_F00D, 1);
        drain("loads");

        // JAL to x1, then to x0 (counts but no write)
        issue_alu(5'd1, 1'b1, 2'b10, 32'h0000_0FFF, 32'h0000_0100);
        issue_alu(5'd0, 1'b1, 2'b10, 32'h0000_0FFF, 32'h0000_0200);
        issue_alu(5'd3, 1'b0, 2'b11, 32'h0000_0033, 32'h0);
        drain("jal");

        // Flushed instruction and stray response in IDLE leave no trace
        set_op(5'd4, 1'b1, 1'b0, 3'b000, 2'd0, 2'b00, 32'h4444, 32'h0);
        flush = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        flush = 1'b0;
        dmem_rsp_valid = 1'b1;
        @(posedge clk);
        #1 dmem_rsp_valid = 1'b0;
        drain("flush_idle");

        // Flush held during WAIT_MEM: load still commits, flushed op never accepted
        push_exp(5'd14, model_load(3'b000, 2'd1, 32'h0000_7F00), 1'b1);
        set_op(5'd14, 1'b1, 1'b1, 3'b000, 2'd1, 2'b01, 32'h0, 32'h0);
        @(posedge clk);
        #1 set_op(5'd15, 1'b1, 1'b0, 3'b000, 2'd0, 2'b00, 32'h1515, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h0000_7F00;
        @(posedge clk);
        #1 dmem_rsp_valid = 1'b0;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        flush = 1'b0;
        drain("flush_wait");

        // Reset while a load is outstanding, then a late response
        set_op(5'd16, 1'b1, 1'b1, 3'b000, 2'd0, 2'b01, 32'h0, 32'h0);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_ready", 64'(ex_ready), 64'd0);
        rst_n = 1'b0;
        exp_cnt = '0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("late_rsp");

        // Four back-to-back ALU ops: one RegWrite pulse per cycle
        for (int i = 0; i < 4; i++) begin
            push_exp(5'(20 + i), 32'hA000_0000 + 32'(i), 1'b1);
            set_op(5'(20 + i), 1'b1, 1'b0, 3'b000, 2'd0, 2'b00, 32'hA000_0000 + 32'(i), 32'h0);
            @(posedge clk);
            #1;
            check_eq("b2b_ready", 64'(ex_ready), 64'd1);
            if (i > 0) check_eq("b2b_we", 64'(RegWrite), 64'd1);
        end
        ex_valid = 1'b0;
        #1 check_eq("b2b_we_last", 64'(RegWrite), 64'd1);
        drain("b2b");
        check_eq("b2b_cnt_is_4", 64'(retire_cnt), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
